// File: rtl/zx_spi_pkg.sv
// Shared types and constants for the ZX SPI master (CPU-side SD card port).
package zx_spi_pkg;

  // Transfer FSM: IDLE waits for a CPU strobe, LOW/HIGH are the two
  // spi_clk half-periods of each bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

  // Byte shifted out when a read launches a background fetch.
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

  // Divider counter width; covers CLK_DIV up to 255.
  localparam int CLK_DIV_W = 8;

endpackage

// File: rtl/zx_spi_master_tick_gen.sv
// Half-period tick generator for the SPI master. Emits a one-cycle tick on
// the last cycle of every CLK_DIV-cycle window while enabled; held at zero
// while disabled or cleared so each transfer starts from a fresh window.
module spi_tick_gen
  import zx_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CLK_DIV_W-1:0] LP_LAST = CLK_DIV_W'(CLK_DIV - 1);

  logic [CLK_DIV_W-1:0] r_cnt;

  // Divider: counts 0..CLK_DIV-1 while enabled, otherwise parked at zero.
  always_ff @(posedge clk_sys) begin
    if (reset || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CLK_DIV_W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/zx_spi_master.sv
// ZX SPI master: turns Z80 port strobes into byte-wide SPI mode-0 transfers
// towards the SD card block. MSB first; MISO sampled on the spi_clk rising
// edge, MOSI updated on the falling edge (or at transfer start).
//
// Build option: define SPI_RD_AUTOXFER_EN to make a data-port read in IDLE
// launch a background transfer of 8'hFF (DivMMC style). Without it, reads
// have no side effects.
//
// Handshake: the CPU strobes (cs_wr, data_wr, data_rd) are single-cycle
// requests accepted only while busy is low; any strobe seen while busy is
// high is dropped. dout is valid from the cycle busy falls until the next
// transfer completes.
module zx_spi_master
  import zx_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cs_wr,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_ss,
  output logic       spi_do,
  input  logic       spi_di
);

`ifdef SPI_RD_AUTOXFER_EN
  localparam logic LP_RD_AUTOXFER = 1'b1;
`else
  localparam logic LP_RD_AUTOXFER = 1'b0;
`endif

  spi_state_e r_state;
  spi_state_e w_next_state;

  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_dout;
  logic       r_busy;
  logic       r_spi_clk;
  logic       r_spi_ss;

  logic [7:0] w_tx;
  logic [7:0] w_rx;
  logic [2:0] w_bit_cnt;
  logic [7:0] w_dout;
  logic       w_busy;
  logic       w_spi_clk;
  logic       w_spi_ss;

  logic       w_idle;
  logic       w_start;
  logic [7:0] w_start_byte;
  logic       w_tick;

  // data_wr has priority over a same-cycle read; a read only ever sends fill.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_start      = w_idle && (data_wr || (data_rd && LP_RD_AUTOXFER));
  assign w_start_byte = data_wr ? din : SPI_FILL_BYTE;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_en    (!w_idle),
    .i_clr   (w_start),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: alternate LOW/HIGH per tick until bit 7's HIGH ends.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next_state = ST_LOW;
      ST_LOW:  if (w_tick)  w_next_state = ST_HIGH;
      ST_HIGH: if (w_tick)  w_next_state = (r_bit_cnt == 3'd7) ? ST_IDLE : ST_LOW;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output/datapath next values for the pins, shift registers and status.
  always_comb begin
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_bit_cnt = r_bit_cnt;
    w_dout    = r_dout;
    w_busy    = r_busy;
    w_spi_clk = r_spi_clk;
    w_spi_ss  = r_spi_ss;
    case (r_state)
      ST_IDLE: begin
        // Chip select only moves between bytes.
        if (cs_wr) w_spi_ss = din[0];
        if (w_start) begin
          w_busy    = 1'b1;
          w_tx      = w_start_byte;
          w_bit_cnt = 3'd0;
        end
      end
      ST_LOW: begin
        if (w_tick) begin
          w_spi_clk = 1'b1;
          w_rx      = {r_rx[6:0], spi_di};
        end
      end
      ST_HIGH: begin
        if (w_tick) begin
          w_spi_clk = 1'b0;
          if (r_bit_cnt == 3'd7) begin
            w_busy = 1'b0;
            w_dout = r_rx;
            // Refill with ones so MOSI idles high.
            w_tx   = 8'hFF;
          end else begin
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_tx      = {r_tx[6:0], 1'b1};
          end
        end
      end
      default: begin
        w_busy    = 1'b0;
        w_spi_clk = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset aborts any transfer on the spot.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_tx      <= 8'hFF;
      r_rx      <= 8'hFF;
      r_bit_cnt <= 3'd0;
      r_dout    <= 8'hFF;
      r_busy    <= 1'b0;
      r_spi_clk <= 1'b0;
      r_spi_ss  <= 1'b1;
    end else begin
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_bit_cnt <= w_bit_cnt;
      r_dout    <= w_dout;
      r_busy    <= w_busy;
      r_spi_clk <= w_spi_clk;
      r_spi_ss  <= w_spi_ss;
    end
  end

  // MOSI is the top of the tx shifter, so it only moves with the shifter.
  assign spi_do  = r_tx[7];
  assign spi_clk = r_spi_clk;
  assign spi_ss  = r_spi_ss;
  assign dout    = r_dout;
  assign busy    = r_busy;

endmodule

// File: tb/tb_zx_spi_master.sv
// Directed bench for zx_spi_master: loopback, fixed MISO and a small SD card
// command responder on the SPI side. Expected dout values are queued when a
// transfer is launched and compared when busy falls.
module tb_zx_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int XFER_CYC = 16 * CLK_DIV;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       cs_wr   = 1'b0;
  logic       data_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] din     = 8'h00;
  logic [7:0] dout;
  logic       busy;
  logic       spi_clk;
  logic       spi_ss;
  logic       spi_do;
  logic       spi_di;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // MISO source: 0 = loopback of MOSI, 1 = fixed level, 2 = card model.
  int   di_mode = 0;
  logic fix_di  = 1'b0;

  // Card model state.
  logic [7:0] c_rx = 8'hFF;
  logic [7:0] c_tx = 8'hFF;
  logic [7:0] c_b;
  logic [7:0] c_nxt;
  int         c_bits = 0;
  int         c_idx  = 0;
  logic       c_done = 1'b0;
  logic [7:0] c_q[$];

  // Bus monitors.
  int         pulse_cnt = 0;
  logic [7:0] mosi_sr   = 8'h00;
  int         busy_cnt  = 0;
  int         p0 = 0;
  int         b0 = 0;
  int         p1 = 0;
  int         guard = 0;
  logic       seen01 = 1'b0;
  logic [7:0] cmd0[6];
  logic [7:0] ff_exp[3];

  // Clock generation.
  always #5 clk_sys = ~clk_sys;

  assign spi_di = (di_mode == 0) ? spi_do : (di_mode == 1) ? fix_di : c_tx[7];

  zx_spi_master #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cs_wr   (cs_wr),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .spi_clk (spi_clk),
    .spi_ss  (spi_ss),
    .spi_do  (spi_do),
    .spi_di  (spi_di)
  );

  always @(posedge spi_clk) begin
    pulse_cnt <= pulse_cnt + 1;
    mosi_sr   <= {mosi_sr[6:0], spi_do};
  end

  always @(posedge clk_sys) begin
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Card: collects a 6-byte command starting 01xxxxxx, answers FF then R1=01.
  always @(posedge spi_clk) begin
    if (di_mode == 2 && !spi_ss) begin
      c_b = {c_rx[6:0], spi_do};
      c_rx <= c_b;
      if (c_bits == 7) begin
        c_bits <= 0;
        c_done <= 1'b1;
        if (c_idx == 0) begin
          if (c_b[7:6] == 2'b01) c_idx <= 1;
        end else if (c_idx == 5) begin
          c_idx <= 0;
          c_q.push_back(8'hFF);
          c_q.push_back(8'h01);
        end else begin
          c_idx <= c_idx + 1;
        end
      end else begin
        c_bits <= c_bits + 1;
      end
    end
  end

  always @(negedge spi_clk) begin
    if (di_mode == 2 && !spi_ss) begin
      if (c_done) begin
        c_done <= 1'b0;
        c_nxt = (c_q.size() > 0) ? c_q.pop_front() : 8'hFF;
        c_tx <= c_nxt;
      end else begin
        c_tx <= {c_tx[6:0], 1'b1};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic push, input logic [7:0] exp);
    @(negedge clk_sys);
    b0 = busy_cnt;
    p0 = pulse_cnt;
    din = b;
    data_wr = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk_sys);
    data_wr = 1'b0;
  endtask

  task automatic cs_write(input logic v);
    @(negedge clk_sys);
    din = {7'd0, v};
    cs_wr = 1'b1;
    @(negedge clk_sys);
    cs_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] e;
    int g;
    g = 0;
    while (busy && g < XFER_CYC + 40) begin
      @(negedge clk_sys);
      g++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    check({tag, "_busy_len"}, busy_cnt - b0, XFER_CYC);
    check({tag, "_pulses"}, pulse_cnt - p0, 8);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, {24'd0, dout}, {24'd0, e});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00;
    cmd0[3] = 8'h00; cmd0[4] = 8'h00; cmd0[5] = 8'h95;
    ff_exp[0] = 8'hFF; ff_exp[1] = 8'h01; ff_exp[2] = 8'hFF;

    // Reset and idle.
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("rst_ss",   {31'd0, spi_ss},  32'd1);
    check("rst_clk",  {31'd0, spi_clk}, 32'd0);
    check("rst_do",   {31'd0, spi_do},  32'd1);
    check("rst_dout", {24'd0, dout},    32'hFF);
    check("rst_busy", {31'd0, busy},    32'd0);

    // Loopback byte 0x40.
    di_mode = 0;
    start_xfer(8'h40, 1'b1, 8'h40);
    check("wr40_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("wr40");
    check("wr40_mosi", {24'd0, mosi_sr}, 32'h40);

    // Select card, transfer A5 with MISO low, strobes mid-transfer ignored.
    cs_write(1'b0);
    check("cs0_ss", {31'd0, spi_ss}, 32'd0);
    di_mode = 1;
    fix_di  = 1'b0;
    start_xfer(8'hA5, 1'b1, 8'h00);
    repeat (20) @(negedge clk_sys);
    din = 8'h00;
    data_wr = 1'b1;
    @(negedge clk_sys);
    data_wr = 1'b0;
    din = 8'h01;
    cs_wr = 1'b1;
    @(negedge clk_sys);
    cs_wr = 1'b0;
    data_rd = 1'b1;
    @(negedge clk_sys);
    data_rd = 1'b0;
    check("a5_ss_mid", {31'd0, spi_ss}, 32'd0);
    wait_done("a5");
    check("a5_mosi", {24'd0, mosi_sr}, 32'hA5);
    check("a5_ss_end", {31'd0, spi_ss}, 32'd0);
    repeat (3) @(negedge clk_sys);
    check("a5_no_restart", {31'd0, busy}, 32'd0);
    cs_write(1'b1);
    check("cs1_ss", {31'd0, spi_ss}, 32'd1);

    // data_wr and data_rd together: the write byte goes out.
    di_mode = 0;
    @(negedge clk_sys);
    b0 = busy_cnt;
    p0 = pulse_cnt;
    din = 8'h3C;
    data_wr = 1'b1;
    data_rd = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk_sys);
    data_wr = 1'b0;
    data_rd = 1'b0;
    wait_done("wrrd");
    check("wrrd_mosi", {24'd0, mosi_sr}, 32'h3C);

    // CMD0 to the card model, then poll with FF for R1.
    di_mode = 2;
    cs_write(1'b0);
    for (int i = 0; i < 6; i++) begin
      start_xfer(cmd0[i], 1'b1, 8'hFF);
      wait_done("cmd0");
    end
    for (int i = 0; i < 3; i++) begin
      start_xfer(8'hFF, 1'b1, ff_exp[i]);
      wait_done("r1");
      if (dout == 8'h01) seen01 = 1'b1;
    end
    check("r1_seen", {31'd0, seen01}, 32'd1);
    cs_write(1'b1);

    // Data-port read in IDLE.
    di_mode = 0;
    start_xfer(8'h5A, 1'b1, 8'h5A);
    wait_done("pre_rd");
    di_mode = 1;
    fix_di  = 1'b1;
    @(negedge clk_sys);
    b0 = busy_cnt;
    p0 = pulse_cnt;
    data_rd = 1'b1;
    @(negedge clk_sys);
    data_rd = 1'b0;
`ifdef SPI_RD_AUTOXFER_EN
    exp_q.push_back(8'hFF);
    check("rd_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("rd_auto");
    check("rd_mosi", {24'd0, mosi_sr}, 32'hFF);
`else
    repeat (40) @(negedge clk_sys);
    check("rd_no_pulses", pulse_cnt - p0, 0);
    check("rd_no_busy", {31'd0, busy}, 32'd0);
    check("rd_dout_kept", {24'd0, dout}, 32'h5A);
`endif

    // Reset during bit 3.
    di_mode = 0;
    start_xfer(8'hF0, 1'b0, 8'h00);
    guard = 0;
    while ((pulse_cnt - p0) < 4 && guard < XFER_CYC) begin
      @(negedge clk_sys);
      guard++;
    end
    check("rst_mid_reached", pulse_cnt - p0, 4);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_clk",  {31'd0, spi_clk}, 32'd0);
    check("rst_mid_busy", {31'd0, busy},    32'd0);
    check("rst_mid_do",   {31'd0, spi_do},  32'd1);
    check("rst_mid_dout", {24'd0, dout},    32'hFF);
    reset = 1'b0;
    p1 = pulse_cnt;
    repeat (40) @(negedge clk_sys);
    check("rst_mid_no_edges", pulse_cnt - p1, 0);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zx_spi_master.md
Name: zx_spi_master

Overview:
CPU-facing SPI master that sits directly upstream of the SD card emulation block. It turns Z80 port accesses (chip-select register write, data-port write/read) into byte-wide SPI mode-0 transfers on spi_clk/spi_ss/spi_do. It returns the byte clocked back on spi_di to the CPU.
Its SPI pins connect one-to-one to the card block's spi_clk, spi_ss, spi_di and spi_do, with MOSI and MISO crossed.

Parameters:
CLK_DIV, 4, clk_sys cycles per SPI clock half-period; legal range 2..255; sets the spi_clk period to 2*CLK_DIV cycles.

Ports:
clk_sys  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
cs_wr  in  1  1-cycle strobe; loads the chip-select register from din[0].
data_wr  in  1  1-cycle strobe; starts a transfer of din.
data_rd  in  1  1-cycle strobe; CPU read of the data port.
din  in  8  CPU write data.
dout  out  8  last received byte.
busy  out  1  high while a transfer is in progress.
spi_clk  out  1  SPI clock; idles low (mode 0).
spi_ss  out  1  card select, active low.
spi_do  out  1  MOSI, MSB first; idles high.
spi_di  in  1  MISO.

Behaviour:
- Reset values: spi_ss=1, spi_clk=0, spi_do=1, dout=8'hFF, busy=0, state IDLE. Reset mid-transfer aborts immediately, with no further spi_clk edges.
- States: IDLE, LOW, HIGH. A divider counter counts 0..CLK_DIV-1. A 3-bit bit_cnt counts bits. There is an 8-bit tx shift register and an 8-bit rx shift register.
- IDLE + data_wr at cycle T:
  - At T+1: busy=1, tx=din, spi_do=din[7], bit_cnt=0, state LOW, divider cleared.
- LOW, divider at CLK_DIV-1: spi_clk<=1, rx<={rx[6:0],spi_di}, state HIGH.
- HIGH, divider at CLK_DIV-1: spi_clk<=0.
  - If bit_cnt==7: state IDLE, busy<=0, dout<=final rx value (including the bit sampled this transfer), spi_do<=1.
  - Else: bit_cnt+1, spi_do<=next tx bit, state LOW.
- Latency: busy is high for exactly 16*CLK_DIV cycles. dout is valid in the cycle busy falls.
- spi_do changes only on spi_clk falling edges or at transfer start, so it is stable at least CLK_DIV cycles before each rising edge.
- data_wr while busy: ignored, and the transfer in progress is unaffected.
- cs_wr while busy: ignored. spi_ss never changes mid-byte.
- cs_wr in IDLE: spi_ss<=din[0] on the next cycle.
- data_wr and data_rd in the same cycle: data_wr wins.
- data_rd in IDLE: dout is unchanged by the read itself. Auto-transfer behaviour is covered under Optional Feature.
- Transfers also run with spi_ss=1; the card side simply ignores them. This is used for the card's 80-clock power-up sequence.

Optional Feature:
SPI_RD_AUTOXFER_EN
- Defined: data_rd in IDLE starts a transfer of 8'hFF exactly as data_wr would. The CPU reads the previous dout, and the next byte is fetched in the background (DivMMC behaviour).
- Undefined: data_rd has no side effects, and only data_wr starts transfers.
- In both cases, data_rd while busy is ignored.

Decomposition:
- Package zx_spi_pkg:
  - state enum {ST_IDLE, ST_LOW, ST_HIGH}
  - SPI_FILL_BYTE = 8'hFF
  - CLK_DIV width constant
- Sub-module spi_tick_gen: divider producing a 1-cycle half-period tick, enabled only in LOW/HIGH and cleared at transfer start.
- The FSM and shift registers stay in the top module.

Test Plan:
- Reset, then idle 20 cycles -> spi_ss=1, spi_clk=0, spi_do=1, dout=8'hFF, busy=0.
- CLK_DIV=4, spi_di looped from spi_do, data_wr din=8'h40 -> 8 spi_clk pulses, MOSI pattern 0,1,0,0,0,0,0,0, busy high 64 cycles, dout=8'h40.
- cs_wr din=0, then data_wr 8'hA5 with spi_di tied to 0; mid-transfer apply data_wr 8'h00 and cs_wr din=1 -> both ignored, spi_ss stays 0, dout=8'h00 after 64 cycles, then cs_wr din=1 -> spi_ss=1.
- Connected to sd_card model, CMD0 sequence (40 00 00 00 00 95) then FF bytes -> a later dout=8'h01.
- SPI_RD_AUTOXFER_EN defined, spi_di=1, data_rd -> transfer of 8'hFF starts next cycle, dout becomes 8'hFF. Undefined: no spi_clk edges.
- Reset asserted at bit 3 of a transfer -> next cycle spi_clk=0, busy=0, spi_do=1, with no further edges.
